// File: rtl/nms_pkg.sv
// Shared types and width helpers for the FAST->NMS frame controller.
package nms_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } ctrl_state_e;

  // Bit width needed to index n values, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of an x or y coordinate for a dimension of n pixels.
  function automatic int coord_w(input int n);
    return cnt_w(n);
  endfunction

  // Width of the frame-aligned pixel counter.
  function automatic int pix_cnt_w(input int w, input int h);
    return cnt_w(w * h);
  endfunction

  // Width of a per-frame keypoint counter that must reach max_kp itself.
  function automatic int kp_cnt_w(input int max_kp);
    return cnt_w(max_kp + 1);
  endfunction

  localparam int DEF_SCORE_W = 8;
  localparam int DEF_X_W     = coord_w(640);
  localparam int DEF_Y_W     = coord_w(480);

  // Keypoint record for the default 640x480 geometry. Other geometries
  // declare an identically ordered struct with their own field widths.
  typedef struct packed {
    logic [DEF_SCORE_W-1:0] score;
    logic [DEF_X_W-1:0]     x;
    logic [DEF_Y_W-1:0]     y;
  } kp_t;

endpackage

// File: rtl/nms_kp_fifo.sv
// Synchronous keypoint FIFO. A push into a full FIFO succeeds when a pop
// happens in the same cycle. DEPTH must be a power of two (pointer wrap).
module nms_kp_fifo
  import nms_pkg::*;
#(
  parameter type T     = kp_t,
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer/occupancy next-state; a pop frees the slot for a same-cycle push.
  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/nms_frame_ctrl.sv
// Frame sequencer around the FAST->NMS keypoint path: gates pixels into NMS,
// injects a zero-pixel flush after every frame, caps and buffers keypoints,
// and reports frame completion.
// Optional macro NMS_FRAME_STATS_EN adds frame_drop_count / frame_max_score.
module nms_frame_ctrl
  import nms_pkg::*;
#(
  parameter int  SCORE_WIDTH   = 8,
  parameter int  IMAGE_WIDTH   = 640,
  parameter int  IMAGE_HEIGHT  = 480,
  parameter int  FLUSH_LEN     = IMAGE_WIDTH + 2,
  parameter int  MAX_KP        = 500,
  parameter int  KP_FIFO_DEPTH = 16,
  localparam int X_W           = coord_w(IMAGE_WIDTH),
  localparam int Y_W           = coord_w(IMAGE_HEIGHT),
  localparam int KC_W          = kp_cnt_w(MAX_KP)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic                        in_is_corner,
  input  logic [SCORE_WIDTH-1:0]      in_score,
  output logic                        nms_pixel_valid,
  output logic                        nms_is_corner,
  output logic [SCORE_WIDTH-1:0]      nms_score,
  input  logic                        kp_in_valid,
  input  logic [SCORE_WIDTH-1:0]      kp_in_score,
  input  logic [X_W-1:0]              kp_in_x,
  input  logic [Y_W-1:0]              kp_in_y,
  output logic                        kp_out_valid,
  input  logic                        kp_out_ready,
  output logic [SCORE_WIDTH+X_W+Y_W-1:0] kp_out_data,
  output logic                        frame_done,
  output logic [KC_W-1:0]             frame_kp_count,
  output logic                        frame_aborted,
  output logic                        kp_overflow,
  output logic                        late_kp
`ifdef NMS_FRAME_STATS_EN
  ,
  output logic [15:0]                 frame_drop_count,
  output logic [SCORE_WIDTH-1:0]      frame_max_score
`endif
);

  localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIX_W = pix_cnt_w(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int FL_W  = cnt_w(FLUSH_LEN);

  typedef struct packed {
    logic [SCORE_WIDTH-1:0] score;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
  } kp_entry_t;

  ctrl_state_e     state_q;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [FL_W-1:0]  flush_cnt_q;
  logic [KC_W-1:0]  kp_cnt_q, kp_cnt_d;
  logic             abort_q;
  logic             frame_done_q;
  logic [KC_W-1:0]  frame_kp_count_q;
  logic             frame_aborted_q;
  logic             kp_overflow_q;
  logic             late_kp_q;

  logic      pix_take, sof_take, early_sof, last_pix, done_enter;
  logic      kp_active, kp_room, kp_push, kp_drop, kp_late;
  logic      fifo_pop, fifo_full, fifo_empty;
  kp_entry_t kp_in_entry, kp_head;

  assign kp_in_entry = '{score: kp_in_score, x: kp_in_x, y: kp_in_y};

  // Pixel gating into NMS: pass-through while streaming, zeros while flushing.
  always_comb begin
    in_ready        = 1'b0;
    nms_pixel_valid = 1'b0;
    nms_is_corner   = 1'b0;
    nms_score       = '0;
    case (state_q)
      IDLE:    in_ready = in_valid & in_sof;
      STREAM:  in_ready = ~in_sof;
      default: in_ready = 1'b0;
    endcase
    pix_take = in_valid & in_ready;
    if (state_q == FLUSH) begin
      nms_pixel_valid = 1'b1;
    end else if (pix_take) begin
      nms_pixel_valid = 1'b1;
      nms_is_corner   = in_is_corner;
      nms_score       = in_score;
    end
  end

  // Frame events and keypoint admission (cap and FIFO space).
  always_comb begin
    sof_take   = (state_q == IDLE) & pix_take;
    early_sof  = (state_q == STREAM) & in_valid & in_sof;
    last_pix   = (state_q == STREAM) & pix_take & (pix_cnt_q == PIX_W'(NPIX - 1));
    done_enter = (state_q == FLUSH) & (flush_cnt_q == FL_W'(FLUSH_LEN - 1));
    kp_active  = (state_q != IDLE);
    fifo_pop   = ~fifo_empty & kp_out_ready;
    kp_room    = (kp_cnt_q < KC_W'(MAX_KP)) & (~fifo_full | fifo_pop);
    kp_push    = kp_in_valid & kp_active & kp_room;
    kp_drop    = kp_in_valid & kp_active & ~kp_room;
    kp_late    = kp_in_valid & ~kp_active;
    kp_cnt_d   = kp_cnt_q + KC_W'(kp_push);
  end

  // Frame FSM with per-frame counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      pix_cnt_q        <= '0;
      flush_cnt_q      <= '0;
      kp_cnt_q         <= '0;
      abort_q          <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_kp_count_q <= '0;
      frame_aborted_q  <= 1'b0;
      kp_overflow_q    <= 1'b0;
      late_kp_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      kp_cnt_q     <= kp_cnt_d;
      if (kp_drop) kp_overflow_q <= 1'b1;
      if (kp_late) late_kp_q     <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sof_take) begin
            state_q   <= STREAM;
            pix_cnt_q <= PIX_W'(1);
            kp_cnt_q  <= '0;
          end
        end
        STREAM: begin
          if (early_sof) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            abort_q     <= 1'b1;
          end else if (last_pix) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            abort_q     <= 1'b0;
          end else if (pix_take) begin
            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
          end
        end
        FLUSH: begin
          if (done_enter) begin
            state_q          <= DONE;
            frame_done_q     <= 1'b1;
            frame_kp_count_q <= kp_cnt_d;
            frame_aborted_q  <= abort_q;
          end else begin
            flush_cnt_q <= flush_cnt_q + FL_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NMS_FRAME_STATS_EN
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic [SCORE_WIDTH-1:0] max_score_q, max_score_d;
  logic [15:0]            frame_drop_count_q;
  logic [SCORE_WIDTH-1:0] frame_max_score_q;

  // Per-frame drop count (saturating) and running maximum accepted score.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    max_score_d = max_score_q;
    if (kp_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (kp_push && (kp_in_score > max_score_q)) max_score_d = kp_in_score;
  end

  // Statistics accumulate over a frame and are latched when it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q         <= '0;
      max_score_q        <= '0;
      frame_drop_count_q <= '0;
      frame_max_score_q  <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      max_score_q <= max_score_d;
      if (sof_take) begin
        drop_cnt_q  <= '0;
        max_score_q <= '0;
      end
      if (done_enter) begin
        frame_drop_count_q <= drop_cnt_d;
        frame_max_score_q  <= max_score_d;
      end
    end
  end

  assign frame_drop_count = frame_drop_count_q;
  assign frame_max_score  = frame_max_score_q;
`endif

  nms_kp_fifo #(
    .T     (kp_entry_t),
    .DEPTH (KP_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (kp_push),
    .data_i  (kp_in_entry),
    .pop_i   (fifo_pop),
    .data_o  (kp_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign kp_out_valid   = ~fifo_empty;
  assign kp_out_data    = kp_head;
  assign frame_done     = frame_done_q;
  assign frame_kp_count = frame_kp_count_q;
  assign frame_aborted  = frame_aborted_q;
  assign kp_overflow    = kp_overflow_q;
  assign late_kp        = late_kp_q;

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// Self-checking bench for nms_frame_ctrl on an 8x4 image, flush of 10,
// two keypoints per frame and a two-entry FIFO.
module tb_nms_frame_ctrl;

  localparam int SW = 8, IW = 8, IH = 4, FL = 10, MK = 2, FD = 2;
  localparam int NP = IW * IH;
  localparam int XW = 3, YW = 2, KCW = 2, DW = SW + XW + YW;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_sof, in_is_corner;
  logic [SW-1:0] in_score;
  logic nms_pixel_valid, nms_is_corner;
  logic [SW-1:0] nms_score;
  logic kp_in_valid;
  logic [SW-1:0] kp_in_score;
  logic [XW-1:0] kp_in_x;
  logic [YW-1:0] kp_in_y;
  logic kp_out_valid, kp_out_ready;
  logic [DW-1:0] kp_out_data;
  logic frame_done, frame_aborted, kp_overflow, late_kp;
  logic [KCW-1:0] frame_kp_count;
`ifdef NMS_FRAME_STATS_EN
  logic [15:0] frame_drop_count;
  logic [SW-1:0] frame_max_score;
`endif

  always #5 clk = ~clk;

  nms_frame_ctrl #(
    .SCORE_WIDTH(SW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
    .FLUSH_LEN(FL), .MAX_KP(MK), .KP_FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_is_corner(in_is_corner), .in_score(in_score),
    .nms_pixel_valid(nms_pixel_valid), .nms_is_corner(nms_is_corner),
    .nms_score(nms_score),
    .kp_in_valid(kp_in_valid), .kp_in_score(kp_in_score),
    .kp_in_x(kp_in_x), .kp_in_y(kp_in_y),
    .kp_out_valid(kp_out_valid), .kp_out_ready(kp_out_ready),
    .kp_out_data(kp_out_data),
    .frame_done(frame_done), .frame_kp_count(frame_kp_count),
    .frame_aborted(frame_aborted), .kp_overflow(kp_overflow),
    .late_kp(late_kp)
`ifdef NMS_FRAME_STATS_EN
    , .frame_drop_count(frame_drop_count), .frame_max_score(frame_max_score)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit            chk_en = 1'b0;
  bit            m_in_frame;
  int            m_flush_left;
  bit            m_done;
  int            m_pix, m_kp;
  bit            m_abort;
  logic [DW-1:0] m_q[$];
  int            m_rep_count;
  bit            m_rep_abort, m_ovf, m_late;
  int            m_drop, m_max, m_rep_drop, m_rep_max;
  int            cyc_cnt = 0;

  function automatic bit m_idle();
    return !m_in_frame && (m_flush_left == 0) && !m_done;
  endfunction

  task automatic m_clear();
    m_in_frame = 0; m_flush_left = 0; m_done = 0; m_pix = 0; m_kp = 0;
    m_abort = 0; m_q.delete(); m_rep_count = 0; m_rep_abort = 0;
    m_ovf = 0; m_late = 0; m_drop = 0; m_max = 0; m_rep_drop = 0; m_rep_max = 0;
  endtask

  always @(posedge clk) begin
    bit idle, pop, push;
    cyc_cnt++;
    if (rst) begin
      m_clear();
    end else begin
      idle = m_idle();
      pop  = (m_q.size() > 0) && kp_out_ready;
      push = 0;
      if (kp_in_valid) begin
        if (idle) m_late = 1;
        else if (m_kp < MK && (m_q.size() < FD || pop)) push = 1;
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (push) begin
        m_kp++;
        if (int'(kp_in_score) > m_max) m_max = int'(kp_in_score);
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({kp_in_score, kp_in_x, kp_in_y});
      if (idle) begin
        if (in_valid && in_sof) begin
          m_in_frame = 1; m_pix = 1; m_kp = 0; m_drop = 0; m_max = 0;
        end
      end else if (m_in_frame) begin
        if (in_valid && in_sof) begin
          m_in_frame = 0; m_flush_left = FL; m_abort = 1;
        end else if (in_valid) begin
          m_pix++;
          if (m_pix == NP) begin
            m_in_frame = 0; m_flush_left = FL; m_abort = 0;
          end
        end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_done = 1;
          m_rep_count = m_kp; m_rep_abort = m_abort;
          m_rep_drop = m_drop; m_rep_max = m_max;
        end
      end else begin
        m_done = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int            nv_count = 0;
  int            done_pulses = 0;
  logic [DW-1:0] out_log[$];
  bit            e_ready, e_nv;

  always @(negedge clk) begin
    if (nms_pixel_valid) nv_count++;
    if (frame_done) done_pulses++;
    if (kp_out_valid && kp_out_ready) out_log.push_back(kp_out_data);
    if (chk_en) begin
      if (m_idle()) e_ready = in_valid && in_sof;
      else if (m_in_frame) e_ready = !in_sof;
      else e_ready = 0;
      e_nv = (m_flush_left > 0 && !m_in_frame) ? 1'b1 : (in_valid && e_ready);
      chk("in_ready", in_ready, e_ready);
      chk("nms_pixel_valid", nms_pixel_valid, e_nv);
      if (e_nv) begin
        chk("nms_is_corner", nms_is_corner, m_in_frame || m_idle() ? in_is_corner : 1'b0);
        chk("nms_score", nms_score, m_in_frame || m_idle() ? in_score : '0);
      end
      chk("kp_out_valid", kp_out_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("kp_out_data", kp_out_data, m_q[0]);
      chk("frame_done", frame_done, m_done);
      chk("frame_kp_count", frame_kp_count, m_rep_count);
      chk("frame_aborted", frame_aborted, m_rep_abort);
      chk("kp_overflow", kp_overflow, m_ovf);
      chk("late_kp", late_kp, m_late);
`ifdef NMS_FRAME_STATS_EN
      chk("frame_drop_count", frame_drop_count, m_rep_drop);
      chk("frame_max_score", frame_max_score, m_rep_max);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input bit sof);
    in_valid = 1'b1; in_sof = sof;
    in_is_corner = 1'($urandom); in_score = SW'($urandom);
  endtask

  task automatic set_kp(input bit v, input logic [DW-1:0] d);
    kp_in_valid = v;
    {kp_in_score, kp_in_x, kp_in_y} = d;
  endtask

  function automatic logic [DW-1:0] mk(input int i);
    return {SW'($urandom), XW'(i), YW'(i)};
  endfunction

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (frame_done) begin ok = 1; break; end
      tick();
    end
  endtask

  logic [DW-1:0] d1, d2, d3, d4, d5;
  int c0, nv0, refused, dp0;
  bit ok, ab_seen, ab_val, held, acc;

  initial begin
    rst = 1; in_valid = 0; in_sof = 0; in_is_corner = 0; in_score = '0;
    set_kp(0, '0); kp_out_ready = 0;
    repeat (2) tick();
    rst = 0; chk_en = 1;
    chk("reset kp_out_valid", kp_out_valid, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_kp_count", frame_kp_count, 0);

    // Non-SOF pixel and keypoint while idle.
    send_pix(0); set_kp(1, mk(7));
    #1;
    chk("idle in_ready", in_ready, 0);
    chk("idle nms_pixel_valid", nms_pixel_valid, 0);
    tick(); set_kp(0, '0);
    repeat (2) tick();
    chk("idle late_kp", late_kp, 1);
    chk("idle kp_overflow", kp_overflow, 0);
    chk("idle kp_out_valid", kp_out_valid, 0);

    // Clean frame with keypoint cap.
    kp_out_ready = 1; out_log.delete();
    d1 = mk(1); d2 = mk(2); d3 = mk(3);
    for (int i = 0; i < NP; i++) begin
      send_pix(i == 0);
      set_kp(i == 5 || i == 10 || i == 15, (i == 5) ? d1 : (i == 10) ? d2 : d3);
      if (i == 0) begin c0 = cyc_cnt; nv0 = nv_count; end
      tick();
    end
    in_valid = 0; in_sof = 0; set_kp(0, '0);
    wait_done(ok);
    chk("clean done seen", ok, 1);
    chk("clean done cycle", cyc_cnt - c0, NP + FL);
    chk("clean nms valid cycles", nv_count - nv0, 42);
    chk("clean aborted", frame_aborted, 0);
    chk("cap frame_kp_count", frame_kp_count, 2);
    chk("cap kp_overflow", kp_overflow, 1);
    chk("cap out count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("cap out0", out_log[0], d1);
      chk("cap out1", out_log[1], d2);
    end
    tick();
    chk("done single pulse", frame_done, 0);

    // Backpressure: fill FIFO, drop third, then pop+push while full.
    rst = 1; tick(); rst = 0;
    chk("rst kp_overflow", kp_overflow, 0);
    chk("rst late_kp", late_kp, 0);
    kp_out_ready = 0; out_log.delete();
    d1 = mk(1); d2 = mk(2); d3 = mk(3); d4 = mk(4); d5 = mk(5);
    for (int i = 0; i < NP; i++) begin
      send_pix(i == 0);
      set_kp(i == 3 || i == 4 || i == 6, (i == 3) ? d1 : (i == 4) ? d2 : d3);
      tick();
    end
    in_valid = 0; in_sof = 0; set_kp(0, '0);
    wait_done(ok);
    chk("bp done seen", ok, 1);
    chk("bp kp_overflow", kp_overflow, 1);
    chk("bp head held", kp_out_data, d1);
    tick();
    for (int i = 0; i < NP; i++) begin
      send_pix(i == 0);
      kp_out_ready = (i == 3) || (i >= 6 && i < 20);
      set_kp(i == 3 || i == 25, (i == 3) ? d4 : d5);
      tick();
    end
    in_valid = 0; in_sof = 0; set_kp(0, '0);
    chk("bp out count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("bp out0", out_log[0], d1);
      chk("bp out1", out_log[1], d2);
      chk("bp out2", out_log[2], d4);
    end
    repeat (4) tick();
    chk("pre-reset kp_out_valid", kp_out_valid, 1);
    rst = 1; tick(); rst = 0;
    chk("midflush kp_out_valid", kp_out_valid, 0);
    chk("midflush frame_kp_count", frame_kp_count, 0);
    chk("midflush kp_overflow", kp_overflow, 0);
    dp0 = done_pulses;
    repeat (20) tick();
    chk("midflush no done", done_pulses - dp0, 0);

    // Early SOF at pixel 20, then a full frame from the pending SOF.
    kp_out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      send_pix(i == 0); tick();
    end
    send_pix(1);
    #1;
    chk("early sof in_ready", in_ready, 0);
    refused = 0; ab_seen = 0; ab_val = 0; ok = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (in_ready) begin ok = 1; tick(); break; end
      refused++;
      tick();
      if (frame_done) begin ab_seen = 1; ab_val = frame_aborted; end
    end
    chk("early sof accepted", ok, 1);
    chk("early sof refused cycles", refused, 12);
    chk("early done seen", ab_seen, 1);
    chk("early frame_aborted", ab_val, 1);
    for (int i = 1; i < NP; i++) begin
      send_pix(0); tick();
    end
    in_valid = 0; in_sof = 0;
    wait_done(ok);
    chk("after early done seen", ok, 1);
    chk("after early aborted", frame_aborted, 0);
    tick();

    // Randomized traffic with pixel holding, occasional SOF and reset.
    held = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!held || ($urandom % 8 == 0)) begin
        send_pix($urandom % 60 == 0);
        in_valid = ($urandom % 4 != 0);
      end
      set_kp($urandom % 5 == 0, mk($urandom % 8));
      kp_out_ready = ($urandom % 3 != 0);
      rst = ($urandom % 600 == 0);
      #1;
      acc = in_valid && in_ready;
      held = in_valid && !acc;
      tick();
    end
    rst = 0; in_valid = 0; in_sof = 0; set_kp(0, '0);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
